// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clk_en_gen fractional clock-enable generator.
// Optional square-wave outputs are enabled with CLK_EN_GEN_SQUARE_EN.
package clk_en_gen_pkg;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Increment giving f_out from f_clk with an acc_w-bit accumulator, rounded to nearest.
  function automatic longint unsigned inc_for(input longint unsigned f_out_khz,
                                              input longint unsigned f_clk_khz,
                                              input int unsigned     acc_w);
    return ((f_out_khz << acc_w) + (f_clk_khz >> 1)) / f_clk_khz;
  endfunction

endpackage

// File: rtl/clk_en_acc.sv
// One phase-accumulator channel: increment register, accumulator, carry-derived enable pulse.
// With CLK_EN_GEN_SQUARE_EN defined it also drives clk_sq, a copy of the accumulator MSB.
module clk_en_acc
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned      ACC_W   = 24,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  input  logic             en,
  input  logic             we,
  input  logic [ACC_W-1:0] wdata,
  output logic             ce
`ifdef CLK_EN_GEN_SQUARE_EN
  ,
  output logic             clk_sq
`endif
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] acc_q;
  logic             ce_q;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_q};
  assign ce  = ce_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= RST_INC;
    end else if (we) begin
      inc_q <= wdata;
    end
  end

  // Outside RUN (or on any config write) the phase is pinned at zero so channels restart aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else if (clear || !run) begin
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else if (en) begin
      acc_q <= sum[ACC_W-1:0];
      ce_q  <= sum[ACC_W];
    end else begin
      ce_q  <= 1'b0;
    end
  end

`ifdef CLK_EN_GEN_SQUARE_EN
  logic sq_q;

  assign clk_sq = sq_q;

  // Tracks the MSB of the accumulator value being registered; holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= 1'b0;
    end else if (clear || !run) begin
      sq_q <= 1'b0;
    end else if (en) begin
      sq_q <= sum[ACC_W-1];
    end
  end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with settle/lock sequencing.
// Define CLK_EN_GEN_SQUARE_EN to add the per-channel clk_sq square-wave outputs.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned              NUM_CH      = 3,
  parameter int unsigned              ACC_W       = 24,
  parameter int unsigned              LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0]  DEF_INC     = '0,
  parameter int unsigned              CH_W        = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
`ifdef CLK_EN_GEN_SQUARE_EN
  ,
  output logic [NUM_CH-1:0] clk_sq
`endif
);

  localparam int unsigned CNT_W = ch_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             locked_q;
  logic             cfg_valid;
  logic             run;
  logic [NUM_CH-1:0] we_ch;

  // Writes to non-existent channels are dropped without disturbing anything.
  assign cfg_valid = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign run       = (state_q == RUN);
  assign locked    = locked_q;

  always_comb begin
    we_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      we_ch[i] = cfg_valid && (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else if (cfg_valid) begin
      state_q  <= SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else if (state_q == SETTLE) begin
      if (cnt_q == CNT_LAST) begin
        state_q  <= RUN;
        locked_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_acc #(
      .ACC_W   (ACC_W),
      .RST_INC (DEF_INC[i*ACC_W +: ACC_W])
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (cfg_valid),
      .run    (run),
      .en     (ch_en[i]),
      .we     (we_ch[i]),
      .wdata  (cfg_inc),
      .ce     (ce[i])
`ifdef CLK_EN_GEN_SQUARE_EN
      ,
      .clk_sq (clk_sq[i])
`endif
    );
  end

endmodule
